// File: rtl/soft_error_handler.sv
// Soft-error recovery controller: re-reads a failing address after a parity hit, retries a
// bounded number of times, escalates to a sticky fatal state, and keeps saturating error stats.
module soft_error_handler #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned IRQ_THRESH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              err_valid,
   input  logic              soft_error_flag,
   input  logic [ADDR_W-1:0] err_addr,
   input  logic              retry_ack,
   input  logic              clear_stats,
   input  logic              clear_fatal,
   output logic              retry_req,
   output logic [ADDR_W-1:0] retry_addr,
   output logic              busy,
   output logic              fatal_error,
   output logic              missed_error,
   output logic [CNT_W-1:0]  error_count,
   output logic              irq
);

   typedef enum logic [1:0] {IDLE, RETRY, WAIT_CHECK, FATAL} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] IRQ_VAL  = CNT_W'(IRQ_THRESH);
   localparam logic [3:0]       RTRY_MAX = 4'(MAX_RETRY);
   localparam logic [15:0]      TO_VAL   = 16'(TIMEOUT);

   state_t              state_q, state_d;
   logic [3:0]          retry_cnt_q, retry_cnt_d;
   logic [15:0]         timer_q, timer_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                missed_q, missed_d;
   logic                irq_q, irq_d;
   logic                hit;
   logic [CNT_W-1:0]    count_inc;
   logic [3:0]          retry_inc;
   logic [15:0]         timer_inc;

   assign hit       = err_valid & soft_error_flag;
   assign count_inc = count_q + CNT_W'(1);
   assign retry_inc = retry_cnt_q + 4'd1;
   assign timer_inc = timer_q + 16'd1;

   always_comb begin
      count_d  = count_q;
      missed_d = missed_q;
      irq_d    = 1'b0;
      // Saturation means the threshold value is crossed at most once per clear.
      if (clear_stats) begin
         count_d  = '0;
         missed_d = 1'b0;
      end else begin
         if (hit && count_q != CNT_MAX) begin
            count_d = count_inc;
            irq_d   = (count_inc == IRQ_VAL);
         end
         if (hit && (state_q == RETRY || state_q == FATAL))
            missed_d = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
      timer_d     = timer_q;
      addr_d      = addr_q;
      case (state_q)
         IDLE: begin
            if (hit) begin
               addr_d      = err_addr;
               retry_cnt_d = '0;
               state_d     = RETRY;
            end
         end
         RETRY: begin
            if (retry_ack) begin
               timer_d = '0;
               state_d = WAIT_CHECK;
            end
         end
         WAIT_CHECK: begin
            // The first valid check result after the re-read is taken as its outcome.
            if (err_valid) begin
               if (!soft_error_flag) begin
                  state_d = IDLE;
               end else begin
                  retry_cnt_d = retry_inc;
                  state_d     = (retry_inc == RTRY_MAX) ? FATAL : RETRY;
               end
            end else begin
               timer_d = timer_inc;
               if (timer_inc == TO_VAL) state_d = FATAL;
            end
         end
         FATAL: begin
            if (clear_fatal) begin
               retry_cnt_d = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         retry_cnt_q <= '0;
         timer_q     <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         missed_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         retry_cnt_q <= retry_cnt_d;
         timer_q     <= timer_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         missed_q    <= missed_d;
         irq_q       <= irq_d;
      end
   end

   assign retry_req    = (state_q == RETRY);
   assign busy         = (state_q != IDLE);
   assign fatal_error  = (state_q == FATAL);
   assign retry_addr   = addr_q;
   assign missed_error = missed_q;
   assign error_count  = count_q;
   assign irq          = irq_q;

endmodule
